// File: rtl/rb_interpolation.sv
// -----------------------------------------------------------------------------
// rb_interpolation
//
// Second demosaic pass, downstream of green interpolation. For each pixel it
// takes a 3x3 raw Bayer window plus the matching 3x3 window of the completed
// green plane. It rebuilds the missing red/blue samples by averaging
// colour differences (C - G) from the neighbours and adding them back onto
// the centre green value.
//
// Three-stage valid/ready pipeline, one pixel per clock when unstalled:
//   stage 1 : per-neighbour colour differences d(k) = raw(k) - green(k)
//   stage 2 : site-dependent selection and rounded averaging (exact, signed)
//   stage 3 : clamp to [0, 2^DATA_W-1], registered outputs
// The write address and end-of-frame flag travel with each pixel.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready is combinational from out_ready)
//   bayer_symbol      centre site: 01 green, 10 red, 11 blue, 00 invalid
//   row_is_red        centre row holds red sites (used at green centres)
//   raw_win           raw 3x3 window, element k=r*3+c at [(k+1)*DATA_W-1 -: DATA_W]
//   green_win         green-plane 3x3 window, same packing
//   in_addr, in_last  sideband carried with the pixel
//   out_valid/out_ready output handshake
//   red_out, green_out, blue_out, out_addr, out_last  registered pixel
// -----------------------------------------------------------------------------
module rb_interpolation #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            bayer_symbol,
    input  logic                  row_is_red,
    input  logic [9*DATA_W-1:0]   raw_win,
    input  logic [9*DATA_W-1:0]   green_win,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     red_out,
    output logic [DATA_W-1:0]     green_out,
    output logic [DATA_W-1:0]     blue_out,
    output logic [ADDR_W-1:0]     out_addr,
    output logic                  out_last
);

    // Difference width: one sign bit over the sample width.
    localparam int DW = DATA_W + 1;
    // Sum width: four differences plus the rounding constant and the centre
    // green fit without overflow, so no saturation is needed before stage 3.
    localparam int SW = DATA_W + 3;

    localparam logic signed [SW-1:0] ONE   = SW'(1);
    localparam logic signed [SW-1:0] TWO   = SW'(2);
    localparam logic signed [SW-1:0] MAX_V = $signed({3'b000, {DATA_W{1'b1}}});

    typedef enum logic [1:0] {
        SYM_INVALID = 2'b00,
        SYM_GREEN   = 2'b01,
        SYM_RED     = 2'b10,
        SYM_BLUE    = 2'b11
    } symbolT;

    function automatic logic signed [SW-1:0] signExt(input logic signed [DW-1:0] a);
        return {{(SW-DW){a[DW-1]}}, a};
    endfunction

    // Round-half-up average of four differences (arithmetic shift = floor).
    function automatic logic signed [SW-1:0] avg4(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b,
                                                  input logic signed [DW-1:0] c,
                                                  input logic signed [DW-1:0] d);
        logic signed [SW-1:0] s;
        s = signExt(a) + signExt(b) + signExt(c) + signExt(d) + TWO;
        return s >>> 2;
    endfunction

    function automatic logic signed [SW-1:0] avg2(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        logic signed [SW-1:0] s;
        s = signExt(a) + signExt(b) + ONE;
        return s >>> 1;
    endfunction

    function automatic logic [DATA_W-1:0] clamp(input logic signed [SW-1:0] v);
        if (v[SW-1])        return '0;
        else if (v > MAX_V) return '1;
        else                return v[DATA_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Handshake: each stage may load when the stage after it is empty or
    // is itself loading, so bubbles collapse and a full pipe still moves.
    // ------------------------------------------------------------------
    logic s1Valid, s2Valid;
    logic ld1, ld2, ld3;

    assign ld3      = !out_valid | out_ready;
    assign ld2      = !s2Valid   | ld3;
    assign ld1      = !s1Valid   | ld2;
    assign in_ready = ld1;

    // ------------------------------------------------------------------
    // Stage 1: colour differences for the eight neighbours.
    // Compact index j maps to window k = 0,1,2,3,5,6,7,8 (centre skipped).
    // ------------------------------------------------------------------
    logic signed [DW-1:0] diffComb [8];

    for (genvar j = 0; j < 8; j++) begin : gDiff
        localparam int K = (j < 4) ? j : j + 1;
        assign diffComb[j] = $signed({1'b0, raw_win[K*DATA_W +: DATA_W]})
                           - $signed({1'b0, green_win[K*DATA_W +: DATA_W]});
    end

    logic signed [DW-1:0] s1Diff [8];
    logic [DATA_W-1:0]    s1Gc, s1Rc;
    symbolT               s1Sym;
    logic                 s1RowRed;
    logic [ADDR_W-1:0]    s1Addr;
    logic                 s1Last;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the clock edge, whatever the order here.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid  <= 1'b0;
            for (int j = 0; j < 8; j++) s1Diff[j] <= '0;
            s1Gc     <= '0;
            s1Rc     <= '0;
            s1Sym    <= SYM_INVALID;
            s1RowRed <= 1'b0;
            s1Addr   <= '0;
            s1Last   <= 1'b0;
        end else if (ld1) begin
            s1Valid  <= in_valid;
            for (int j = 0; j < 8; j++) s1Diff[j] <= diffComb[j];
            s1Gc     <= green_win[4*DATA_W +: DATA_W];
            s1Rc     <= raw_win[4*DATA_W +: DATA_W];
            s1Sym    <= symbolT'(bayer_symbol);
            s1RowRed <= row_is_red;
            s1Addr   <= in_addr;
            s1Last   <= in_last;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: pick neighbours by site type and rebuild R/B as Gc + avg(d).
    // Diagonals (0,2,6,8) are the opposite chroma at red/blue centres; at
    // green centres the horizontal pair (3,5) carries the row's chroma and
    // the vertical pair (1,7) carries the other one.
    // ------------------------------------------------------------------
    logic signed [SW-1:0] gcExt, rcExt, diagAvg, horzAvg, vertAvg;
    logic signed [SW-1:0] redComb, greenComb, blueComb;

    assign gcExt   = $signed({3'b000, s1Gc});
    assign rcExt   = $signed({3'b000, s1Rc});
    assign diagAvg = avg4(s1Diff[0], s1Diff[2], s1Diff[5], s1Diff[7]);
    assign horzAvg = avg2(s1Diff[3], s1Diff[4]);
    assign vertAvg = avg2(s1Diff[1], s1Diff[6]);

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        redComb   = gcExt;
        greenComb = gcExt;
        blueComb  = gcExt;
        case (s1Sym)
            SYM_RED: begin
                redComb  = rcExt;
                blueComb = gcExt + diagAvg;
            end
            SYM_BLUE: begin
                blueComb = rcExt;
                redComb  = gcExt + diagAvg;
            end
            SYM_GREEN: begin
                if (s1RowRed) begin
                    redComb  = gcExt + horzAvg;
                    blueComb = gcExt + vertAvg;
                end else begin
                    blueComb = gcExt + horzAvg;
                    redComb  = gcExt + vertAvg;
                end
            end
            SYM_INVALID: begin
                // Unknown site: pass the raw sample through on all channels.
                redComb   = rcExt;
                greenComb = rcExt;
                blueComb  = rcExt;
            end
        endcase
    end

    logic signed [SW-1:0] s2Red, s2Green, s2Blue;
    logic [ADDR_W-1:0]    s2Addr;
    logic                 s2Last;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2Valid <= 1'b0;
            s2Red   <= '0;
            s2Green <= '0;
            s2Blue  <= '0;
            s2Addr  <= '0;
            s2Last  <= 1'b0;
        end else if (ld2) begin
            s2Valid <= s1Valid;
            s2Red   <= redComb;
            s2Green <= greenComb;
            s2Blue  <= blueComb;
            s2Addr  <= s1Addr;
            s2Last  <= s1Last;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: clamp and register. Loads only when the current output is
    // empty or being accepted, so a stalled pixel stays stable.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            red_out   <= '0;
            green_out <= '0;
            blue_out  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
        end else if (ld3) begin
            out_valid <= s2Valid;
            red_out   <= clamp(s2Red);
            green_out <= clamp(s2Green);
            blue_out  <= clamp(s2Blue);
            out_addr  <= s2Addr;
            out_last  <= s2Last;
        end
    end

endmodule
